// File: rtl/sli_reset_sequencer.sv
// Sequenced active-low reset generator for the SLI clock/reset interface:
// synchronized release, clock-enable pre-roll and sw reset req/ack with counter.
module sli_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int PRE_CLK_CYCLES = 4,
    parameter int HOLD_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_rst_req,
    input  logic [HOLD_W-1:0] sw_rst_len,
    output logic              nreset_out,
    output logic              clk_en,
    output logic              sw_rst_ack,
    output logic [7:0]        rst_count,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        HOLD  = 2'd1,
        CLKON = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] PRE_INIT  = HOLD_W'(PRE_CLK_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [HOLD_W-1:0]      cnt_q, cnt_d;
    logic                   nreset_q, nreset_d;
    logic                   clk_en_q, clk_en_d;
    logic                   ack_q, ack_d;
    logic                   sw_active_q, sw_active_d;
    logic [7:0]             count_q, count_d;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], 1'b1};
        state_d     = state_q;
        cnt_d       = cnt_q;
        sw_active_d = sw_active_q;
        count_d     = count_q;
        ack_d       = 1'b0;
        unique case (state_q)
            SYNC: begin
                if (sync_q[SYNC_STAGES-1]) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = CLKON;
                    cnt_d   = PRE_INIT;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            CLKON: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                    // Only a software-initiated sequence is acknowledged
                    if (sw_active_q) begin
                        ack_d       = 1'b1;
                        sw_active_d = 1'b0;
                        if (count_q != 8'hFF) begin
                            count_d = count_q + 8'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            RUN: begin
                if (sw_rst_req && !ack_q) begin
                    state_d     = HOLD;
                    sw_active_d = 1'b1;
                    cnt_d       = (sw_rst_len == '0) ? HOLD_INIT
                                                     : sw_rst_len - HOLD_W'(1);
                end
            end
            default: state_d = SYNC;
        endcase
        nreset_d = (state_d == RUN);
        clk_en_d = (state_d == CLKON) || (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SYNC;
            sync_q      <= '0;
            cnt_q       <= '0;
            nreset_q    <= 1'b0;
            clk_en_q    <= 1'b0;
            ack_q       <= 1'b0;
            sw_active_q <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            nreset_q    <= nreset_d;
            clk_en_q    <= clk_en_d;
            ack_q       <= ack_d;
            sw_active_q <= sw_active_d;
            count_q     <= count_d;
        end
    end

    assign nreset_out = nreset_q;
    assign clk_en     = clk_en_q;
    assign sw_rst_ack = ack_q;
    assign rst_count  = count_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_sli_reset_sequencer.sv
// Bench for sli_reset_sequencer: timeline model of reset release and
// sw reset sequences, compared every cycle, plus literal checks.
module tb_sli_reset_sequencer;

    localparam int S = 2;
    localparam int H = 16;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [7:0] sw_rst_len = 8'd0;
    logic       nreset_out, clk_en, sw_rst_ack;
    logic [7:0] rst_count;
    logic [1:0] state_o;

    int checks = 0;
    int passes = 0;

    sli_reset_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .sw_rst_req (sw_rst_req),
        .sw_rst_len (sw_rst_len),
        .nreset_out (nreset_out),
        .clk_en     (clk_en),
        .sw_rst_ack (sw_rst_ack),
        .rst_count  (rst_count),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Timeline model: edge index n since reset release; each sequence is
    // described by the edges where HOLD, clock enable and release begin.
    int n = 0;
    int hold_at = S + 1;
    int clk_at = S + 1 + H;
    int rel_at = S + 1 + H + P;
    bit sw = 1'b0;
    int mcount = 0;

    always @(posedge clk) begin
        if (reset) begin
            n = 0;
            hold_at = S + 1;
            clk_at = S + 1 + H;
            rel_at = S + 1 + H + P;
            sw = 1'b0;
            mcount = 0;
        end else begin
            bit in_run, ack_pre;
            int leff;
            n++;
            in_run = (n - 1) >= rel_at;
            ack_pre = sw && ((n - 1) == rel_at);
            if (in_run && sw_rst_req && !ack_pre) begin
                leff = (sw_rst_len == 0) ? H : int'(sw_rst_len);
                hold_at = n;
                clk_at = n + leff;
                rel_at = clk_at + P;
                sw = 1'b1;
            end
            if (sw && n == rel_at && mcount < 255) mcount++;
        end
    end

    function automatic int exp_state();
        if (n < hold_at) return 0;
        if (n < clk_at) return 1;
        if (n < rel_at) return 2;
        return 3;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_state", int'(state_o), 0);
            chk("rst_nreset", int'(nreset_out), 0);
            chk("rst_clk_en", int'(clk_en), 0);
            chk("rst_ack", int'(sw_rst_ack), 0);
            chk("rst_count_r", int'(rst_count), 0);
        end else begin
            chk("state", int'(state_o), exp_state());
            chk("nreset", int'(nreset_out), int'(n >= rel_at));
            chk("clk_en", int'(clk_en), int'(n >= clk_at));
            chk("ack", int'(sw_rst_ack), int'(sw && n == rel_at));
            chk("count", int'(rst_count), mcount);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ack(output int lo_n, output int lo_c);
        bit seen;
        lo_n = 0;
        lo_c = 0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (sw_rst_ack) begin
                seen = 1'b1;
                break;
            end
            if (!nreset_out) lo_n++;
            if (!clk_en) lo_c++;
        end
        if (!seen) chk("ack_timeout", 0, 1);
    endtask

    initial begin
        int lo_n, lo_c, acks;
        bit ok;

        // Power-on
        repeat (5) step();
        chk("por_nreset_lit", int'(nreset_out), 0);
        reset = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (i == 18) chk("por_clk_en_18", int'(clk_en), 0);
            if (i == 19) chk("por_clk_en_19", int'(clk_en), 1);
            if (i == 22) chk("por_nreset_22", int'(nreset_out), 0);
            if (i == 23) chk("por_nreset_23", int'(nreset_out), 1);
            if (i == 23) chk("por_state_23", int'(state_o), 3);
        end
        chk("por_count_lit", int'(rst_count), 0);

        // Sw reset, len 5
        sw_rst_len = 8'd5;
        sw_rst_req = 1'b1;
        wait_ack(lo_n, lo_c);
        sw_rst_req = 1'b0;
        chk("len5_nreset_low", lo_n, 9);
        chk("len5_clk_en_low", lo_c, 5);
        repeat (30) step();
        chk("len5_count_lit", int'(rst_count), 1);

        // len 0 uses the default hold
        sw_rst_len = 8'd0;
        sw_rst_req = 1'b1;
        wait_ack(lo_n, lo_c);
        sw_rst_req = 1'b0;
        chk("len0_nreset_low", lo_n, 20);
        chk("len0_clk_en_low", lo_c, 16);
        repeat (30) step();
        chk("len0_count_lit", int'(rst_count), 2);

        // req held past ack restarts; pulse in HOLD ignored
        sw_rst_len = 8'd3;
        sw_rst_req = 1'b1;
        wait_ack(lo_n, lo_c);
        step();
        step();
        sw_rst_req = 1'b0;
        chk("rearm_state_lit", int'(state_o), 1);
        repeat (2) step();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        wait_ack(lo_n, lo_c);
        repeat (20) step();
        chk("rearm_count_lit", int'(rst_count), 4);
        chk("rearm_state_run", int'(state_o), 3);

        // Randomized requests and lengths
        for (int it = 0; it < 60; it++) begin
            sw_rst_req = 1'($urandom_range(0, 1));
            sw_rst_len = 8'($urandom_range(0, 12));
            repeat ($urandom_range(1, 15)) step();
        end
        sw_rst_req = 1'b0;
        repeat (40) step();

        // Async reset mid-HOLD of a sw sequence
        sw_rst_len = 8'd10;
        sw_rst_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (state_o == 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("hold_timeout", 0, 1);
        sw_rst_req = 1'b0;
        repeat (3) step();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_state", int'(state_o), 0);
        chk("async_nreset", int'(nreset_out), 0);
        chk("async_clk_en", int'(clk_en), 0);
        chk("async_count", int'(rst_count), 0);
        chk("async_ack", int'(sw_rst_ack), 0);
        step();
        step();
        reset = 1'b0;
        repeat (30) step();
        chk("rerun_nreset", int'(nreset_out), 1);
        chk("rerun_count", int'(rst_count), 0);

        // 256 back-to-back sequences saturate the counter
        sw_rst_len = 8'd1;
        sw_rst_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 5000 && acks < 256; i++) begin
            step();
            if (sw_rst_ack) acks++;
        end
        sw_rst_req = 1'b0;
        chk("sat_acks", acks, 256);
        chk("sat_count_lit", int'(rst_count), 255);
        repeat (20) step();
        chk("sat_count_hold", int'(rst_count), 255);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
